// File: rtl/mdu_issue.sv
// Purpose: issues RV32M instructions to a multiply/divide unit, waits for the result and hands it to writeback.
// Latency: accept at T -> o_mdu_valid at T+1; with a one-cycle MDU o_wb_valid at T+3; MDU wait bounded by P_TIMEOUT.
// Backpressure: o_ins_ready only in IDLE; WB holds address/data until i_wb_ready; i_mdu_ready acts as a result strobe.
//
// Ports:
//   i_clk, i_rst                      clock (posedge) and synchronous active-low reset
//   i_ins_valid/o_ins_ready, i_ins    upstream instruction handshake and RV32 instruction word
//   i_rs1_data, i_rs2_data            register-file operands, sampled on accept
//   o_mdu_valid, o_mdu_rs1/rs2/op     request to the MDU; held stable while the request is outstanding
//   i_mdu_ready, i_mdu_rd             MDU result strobe and result (looked at only in ISSUE)
//   o_wb_valid/i_wb_ready             writeback handshake carrying o_wb_addr and o_wb_data
//   o_illegal, o_timeout              one-cycle error pulses
//   o_busy                            high whenever the FSM is not in IDLE
module mdu_issue #(
    parameter int WIDTH     = 32,
    parameter int P_TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ins_valid,
    output logic             o_ins_ready,
    input  logic [31:0]      i_ins,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    output logic             o_mdu_valid,
    output logic [WIDTH-1:0] o_mdu_rs1,
    output logic [WIDTH-1:0] o_mdu_rs2,
    output logic [2:0]       o_mdu_op,
    input  logic             i_mdu_ready,
    input  logic [WIDTH-1:0] i_mdu_rd,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic [4:0]       o_wb_addr,
    output logic [WIDTH-1:0] o_wb_data,
    output logic             o_illegal,
    output logic             o_timeout,
    output logic             o_busy
);

    // One extra bit so the incremented count can represent P_TIMEOUT itself.
    localparam int CW = $clog2(P_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             accept;
    logic             legal;
    logic             mdu_done;
    logic             to_hit;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;

    logic [WIDTH-1:0] rs1_q;
    logic [WIDTH-1:0] rs2_q;
    logic [WIDTH-1:0] res_q;
    logic [2:0]       op_q;
    logic [4:0]       rd_q;
    logic             illegal_q;
    logic             timeout_q;

    // Source-register index fields are not needed here; operands arrive already read.
    logic             unused_rs_fields;
    assign unused_rs_fields = ^i_ins[24:15];

    assign accept   = i_ins_valid && (state == IDLE);
    assign legal    = (i_ins[6:0] == 7'b0110011) && (i_ins[31:25] == 7'b0000001);
    assign mdu_done = (state == ISSUE) && i_mdu_ready;
    assign cnt_inc  = cnt + CW'(1);
    // A result arriving in the last allowed cycle wins over the timeout.
    assign to_hit   = (state == ISSUE) && !i_mdu_ready && (cnt_inc == CW'(P_TIMEOUT));

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && legal) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (i_mdu_ready) begin
                    // Writes to x0 are discarded, so skip the writeback handshake.
                    state_nxt = (rd_q != 5'd0) ? WB : IDLE;
                end else if (to_hit) begin
                    state_nxt = IDLE;
                end
            end
            WB: begin
                if (i_wb_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; o_mdu_valid comes from the state so it drops the cycle after the strobe.
    always_comb begin
        o_ins_ready = 1'b0;
        o_mdu_valid = 1'b0;
        o_wb_valid  = 1'b0;
        o_busy      = 1'b0;
        case (state)
            IDLE: begin
                o_ins_ready = 1'b1;
            end
            ISSUE: begin
                o_mdu_valid = 1'b1;
                o_busy      = 1'b1;
            end
            WB: begin
                o_wb_valid = 1'b1;
                o_busy     = 1'b1;
            end
            default: begin
                o_busy = 1'b1;
            end
        endcase
    end

    // Captured operands, result, timeout counter and error pulses
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            res_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            cnt       <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (accept && legal) begin
                rs1_q <= i_rs1_data;
                rs2_q <= i_rs2_data;
                op_q  <= i_ins[14:12];
                rd_q  <= i_ins[11:7];
                cnt   <= '0;
            end else if ((state == ISSUE) && !i_mdu_ready) begin
                cnt <= cnt_inc;
            end
            if (mdu_done) begin
                res_q <= i_mdu_rd;
            end
            illegal_q <= accept && !legal;
            timeout_q <= to_hit;
        end
    end

    assign o_mdu_rs1 = rs1_q;
    assign o_mdu_rs2 = rs2_q;
    assign o_mdu_op  = op_q;
    assign o_wb_addr = rd_q;
    assign o_wb_data = res_q;
    assign o_illegal = illegal_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_mdu_issue.sv
// Purpose: self-checking bench for mdu_issue with a behavioural MDU stub and a writeback scoreboard.
// Latency: stub answers a configurable number of cycles after it first sees o_mdu_valid.
// Backpressure: i_wb_ready is withheld per vector to exercise writeback stalls.
module tb_mdu_issue;

    logic        i_clk;
    logic        i_rst;
    logic        i_ins_valid;
    logic        o_ins_ready;
    logic [31:0] i_ins;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        o_mdu_valid;
    logic [31:0] o_mdu_rs1;
    logic [31:0] o_mdu_rs2;
    logic [2:0]  o_mdu_op;
    logic        i_mdu_ready;
    logic [31:0] i_mdu_rd;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic [4:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic        o_illegal;
    logic        o_timeout;
    logic        o_busy;

    mdu_issue #(.WIDTH(32), .P_TIMEOUT(64)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ins_valid (i_ins_valid),
        .o_ins_ready (o_ins_ready),
        .i_ins       (i_ins),
        .i_rs1_data  (i_rs1_data),
        .i_rs2_data  (i_rs2_data),
        .o_mdu_valid (o_mdu_valid),
        .o_mdu_rs1   (o_mdu_rs1),
        .o_mdu_rs2   (o_mdu_rs2),
        .o_mdu_op    (o_mdu_op),
        .i_mdu_ready (i_mdu_ready),
        .i_mdu_rd    (i_mdu_rd),
        .o_wb_valid  (o_wb_valid),
        .i_wb_ready  (i_wb_ready),
        .o_wb_addr   (o_wb_addr),
        .o_wb_data   (o_wb_data),
        .o_illegal   (o_illegal),
        .o_timeout   (o_timeout),
        .o_busy      (o_busy)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          lat;
        int          stall;
        bit          exp_wb;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        bit          exp_ill;
        int          exp_cyc;
    } vec_t;

    int          checks;
    int          errors;
    int          ready_cnt;
    int          stub_lat;
    bit          stub_en;
    bit          late_pulse;
    logic [36:0] wb_q[$];
    vec_t        vecs[11];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ins(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, rd, opc};
    endfunction

    // Reference RV32M behaviour, including the divide-by-zero and overflow cases.
    function automatic logic [31:0] mdu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        r  = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0)                                r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else                                           r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0)                                r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else                                           r = $signed(a) % $signed(b);
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // MDU stub: answers stub_lat+1 cycles into the request and checks request stability.
    initial begin
        int          wait_cnt;
        bit          gave;
        bit          hold_ok;
        logic [2:0]  l_op;
        logic [31:0] l_rs1;
        logic [31:0] l_rs2;
        i_mdu_ready = 1'b0;
        i_mdu_rd    = '0;
        wait_cnt    = 0;
        gave        = 1'b0;
        l_op        = '0;
        l_rs1       = '0;
        l_rs2       = '0;
        forever begin
            @(posedge i_clk);
            #2;
            hold_ok = (o_mdu_op == l_op) && (o_mdu_rs1 == l_rs1) && (o_mdu_rs2 == l_rs2);
            if (i_mdu_ready) begin
                i_mdu_ready = 1'b0;
                if (gave) begin
                    chk("valid_drop_after_ready", {31'd0, o_mdu_valid}, 32'd0);
                    chk("operand_hold_after_ready", {31'd0, hold_ok}, 32'd1);
                end
                gave     = 1'b0;
                wait_cnt = 0;
            end else if (late_pulse) begin
                i_mdu_ready = 1'b1;
                i_mdu_rd    = 32'hDEAD_BEEF;
            end else if (o_mdu_valid) begin
                if (wait_cnt == 0) begin
                    l_op  = o_mdu_op;
                    l_rs1 = o_mdu_rs1;
                    l_rs2 = o_mdu_rs2;
                end else begin
                    chk("operand_hold_issue", {31'd0, hold_ok}, 32'd1);
                end
                wait_cnt++;
                if (stub_en && wait_cnt == stub_lat + 1) begin
                    i_mdu_ready = 1'b1;
                    i_mdu_rd    = mdu_model(o_mdu_op, o_mdu_rs1, o_mdu_rs2);
                    gave        = 1'b1;
                    ready_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Writeback scoreboard: pops on each completed writeback handshake.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge i_clk);
            if (i_rst && o_wb_valid && i_wb_ready) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_writeback", {27'd0, o_wb_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = wb_q.pop_front();
                    chk("sb_wb_addr", {27'd0, o_wb_addr}, {27'd0, e[36:32]});
                    chk("sb_wb_data", o_wb_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!o_ins_ready && n < 100) begin
            tick();
            n++;
        end
        chk("ins_ready_wait", {31'd0, o_ins_ready}, 32'd1);
    endtask

    task automatic drive_ins(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        i_ins       = ins;
        i_rs1_data  = a;
        i_rs2_data  = b;
        i_ins_valid = 1'b1;
        tick();
        i_ins_valid = 1'b0;
        i_ins       = $urandom;
        i_rs1_data  = $urandom;
        i_rs2_data  = $urandom;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        int rc0;
        bit saw_to;
        wait_ready();
        stub_en    = 1'b1;
        stub_lat   = v.lat;
        rc0        = ready_cnt;
        i_wb_ready = (v.stall == 0);
        if (v.exp_wb) wb_q.push_back({v.exp_addr, v.exp_data});
        drive_ins(v.ins, v.rs1, v.rs2);
        if (v.exp_ill) begin
            chk($sformatf("v%0d_illegal_pulse", idx), {31'd0, o_illegal}, 32'd1);
            chk($sformatf("v%0d_illegal_no_mdu", idx), {31'd0, o_mdu_valid}, 32'd0);
            chk($sformatf("v%0d_illegal_idle", idx), {31'd0, o_ins_ready}, 32'd1);
            tick();
            chk($sformatf("v%0d_illegal_one_cycle", idx), {31'd0, o_illegal}, 32'd0);
            chk($sformatf("v%0d_illegal_no_mdu2", idx), {31'd0, o_mdu_valid}, 32'd0);
            return;
        end
        chk($sformatf("v%0d_mdu_valid_t1", idx), {31'd0, o_mdu_valid}, 32'd1);
        chk($sformatf("v%0d_ins_ready_low", idx), {31'd0, o_ins_ready}, 32'd0);
        chk($sformatf("v%0d_busy", idx), {31'd0, o_busy}, 32'd1);
        k      = 1;
        saw_to = 1'b0;
        while (k < 200) begin
            if (o_timeout) saw_to = 1'b1;
            if (o_wb_valid || !o_busy) break;
            tick();
            k++;
        end
        chk($sformatf("v%0d_no_timeout", idx), {31'd0, saw_to}, 32'd0);
        if (v.exp_wb) begin
            chk($sformatf("v%0d_wb_cycle", idx), k, v.exp_cyc);
            chk($sformatf("v%0d_wb_valid", idx), {31'd0, o_wb_valid}, 32'd1);
            chk($sformatf("v%0d_wb_addr", idx), {27'd0, o_wb_addr}, {27'd0, v.exp_addr});
            chk($sformatf("v%0d_wb_data", idx), o_wb_data, v.exp_data);
            for (int s = 0; s < v.stall; s++) begin
                chk($sformatf("v%0d_stall%0d_valid", idx, s), {31'd0, o_wb_valid}, 32'd1);
                chk($sformatf("v%0d_stall%0d_addr", idx, s), {27'd0, o_wb_addr}, {27'd0, v.exp_addr});
                chk($sformatf("v%0d_stall%0d_data", idx, s), o_wb_data, v.exp_data);
                chk($sformatf("v%0d_stall%0d_ins_ready", idx, s), {31'd0, o_ins_ready}, 32'd0);
                tick();
            end
            i_wb_ready = 1'b1;
            tick();
            chk($sformatf("v%0d_wb_drop", idx), {31'd0, o_wb_valid}, 32'd0);
            chk($sformatf("v%0d_idle_after_wb", idx), {31'd0, o_ins_ready}, 32'd1);
        end else begin
            chk($sformatf("v%0d_no_wb", idx), {31'd0, o_wb_valid}, 32'd0);
            chk($sformatf("v%0d_idle_no_wb", idx), {31'd0, o_ins_ready}, 32'd1);
        end
        chk($sformatf("v%0d_mdu_handshakes", idx), ready_cnt - rc0, 32'd1);
    endtask

    initial begin
        int n;
        checks      = 0;
        errors      = 0;
        ready_cnt   = 0;
        stub_en     = 1'b1;
        stub_lat    = 1;
        late_pulse  = 1'b0;
        i_rst       = 1'b0;
        i_ins_valid = 1'b0;
        i_ins       = '0;
        i_rs1_data  = '0;
        i_rs2_data  = '0;
        i_wb_ready  = 1'b1;

        //           ins                                          rs1           rs2           lat stl wb addr   data         ill cyc
        vecs[0]  = '{mk_ins(7'h01, 3'b000, 5'd5,  7'h33), 32'd7,        32'hFFFF_FFFD, 1,  0, 1, 5'd5,  32'hFFFF_FFEB, 0, 3};
        vecs[1]  = '{mk_ins(7'h01, 3'b100, 5'd10, 7'h33), 32'hFFFF_FFEC, 32'd3,        4,  0, 1, 5'd10, 32'hFFFF_FFFA, 0, 6};
        vecs[2]  = '{mk_ins(7'h01, 3'b111, 5'd12, 7'h33), 32'd20,       32'd6,         2,  5, 1, 5'd12, 32'd2,         0, 4};
        vecs[3]  = '{mk_ins(7'h01, 3'b001, 5'd0,  7'h33), 32'h1234_5678, 32'h9ABC_DEF0, 1,  0, 0, 5'd0,  32'd0,         0, 0};
        vecs[4]  = '{mk_ins(7'h00, 3'b000, 5'd6,  7'h33), 32'd1,        32'd2,         1,  0, 0, 5'd0,  32'd0,         1, 0};
        vecs[5]  = '{mk_ins(7'h01, 3'b011, 5'd31, 7'h33), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  0, 1, 5'd31, 32'hFFFF_FFFE, 0, 3};
        vecs[6]  = '{mk_ins(7'h01, 3'b101, 5'd1,  7'h33), 32'd1234,     32'd0,         3,  0, 1, 5'd1,  32'hFFFF_FFFF, 0, 5};
        vecs[7]  = '{mk_ins(7'h01, 3'b010, 5'd3,  7'h33), 32'hFFFF_FFFF, 32'd2,        2,  0, 1, 5'd3,  32'hFFFF_FFFF, 0, 4};
        vecs[8]  = '{mk_ins(7'h01, 3'b110, 5'd7,  7'h33), 32'hFFFF_FFF9, 32'd2,        1,  0, 1, 5'd7,  32'hFFFF_FFFF, 0, 3};
        vecs[9]  = '{mk_ins(7'h01, 3'b000, 5'd8,  7'h13), 32'd3,        32'd4,         1,  0, 0, 5'd0,  32'd0,         1, 0};
        // Result strobe lands in the 64th ISSUE cycle, together with the timeout condition.
        vecs[10] = '{mk_ins(7'h01, 3'b000, 5'd9,  7'h33), 32'd3,        32'd5,         63, 0, 1, 5'd9,  32'd15,        0, 65};

        // Reset state
        tick();
        tick();
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_mdu_valid", {31'd0, o_mdu_valid}, 32'd0);
        chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        chk("rst_illegal", {31'd0, o_illegal}, 32'd0);
        chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
        i_rst = 1'b1;
        tick();
        chk("post_rst_ins_ready", {31'd0, o_ins_ready}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end

        // Timeout: MDU never answers.
        wait_ready();
        stub_en    = 1'b0;
        i_wb_ready = 1'b1;
        drive_ins(mk_ins(7'h01, 3'b100, 5'd4, 7'h33), 32'd100, 32'd7);
        n = 0;
        while (o_mdu_valid && n < 200) begin
            n++;
            tick();
        end
        chk("timeout_issue_cycles", n, 32'd64);
        chk("timeout_pulse", {31'd0, o_timeout}, 32'd1);
        chk("timeout_idle", {31'd0, o_ins_ready}, 32'd1);
        chk("timeout_no_wb", {31'd0, o_wb_valid}, 32'd0);
        tick();
        chk("timeout_one_cycle", {31'd0, o_timeout}, 32'd0);
        stub_en = 1'b1;

        // Reset in the middle of a DIV, then a late strobe that must be ignored.
        wait_ready();
        stub_lat = 10;
        drive_ins(mk_ins(7'h01, 3'b100, 5'd10, 7'h33), 32'hFFFF_FFEC, 32'd3);
        tick();
        tick();
        chk("middiv_in_issue", {31'd0, o_mdu_valid}, 32'd1);
        i_rst = 1'b0;
        tick();
        chk("middiv_busy", {31'd0, o_busy}, 32'd0);
        chk("middiv_mdu_valid", {31'd0, o_mdu_valid}, 32'd0);
        chk("middiv_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        chk("middiv_illegal", {31'd0, o_illegal}, 32'd0);
        chk("middiv_timeout", {31'd0, o_timeout}, 32'd0);
        chk("middiv_rs1", o_mdu_rs1, 32'd0);
        chk("middiv_rs2", o_mdu_rs2, 32'd0);
        chk("middiv_op", {29'd0, o_mdu_op}, 32'd0);
        chk("middiv_wb_addr", {27'd0, o_wb_addr}, 32'd0);
        chk("middiv_wb_data", o_wb_data, 32'd0);
        i_rst = 1'b1;
        tick();
        chk("middiv_release_ready", {31'd0, o_ins_ready}, 32'd1);
        late_pulse = 1'b1;
        tick();
        late_pulse = 1'b0;
        tick();
        tick();
        chk("late_ready_busy", {31'd0, o_busy}, 32'd0);
        chk("late_ready_no_wb", {31'd0, o_wb_valid}, 32'd0);
        chk("late_ready_wb_data", o_wb_data, 32'd0);

        // Normal operation resumes after the abort.
        run_vec(vecs[0], 11);
        tick();
        chk("scoreboard_drained", wb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
